pulse_stretch_bank: RTL and testbench

PULSE_STRETCH_BANK -- requirements
Module: pulse_stretch_bank

---
 rtl/pulse_stretch_pkg.sv | 19 +
 rtl/pulse_stretch_channel.sv | 96 +++++++++
 rtl/pulse_stretch_bank.sv | 54 +++++
 tb/tb_pulse_stretch_bank.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/pulse_stretch_pkg.sv
// Shared types and parameter limits for the pulse stretcher bank.
package pulse_stretch_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } chanState_t;

  localparam int MIN_CHANNELS   = 1;
  localparam int MAX_CHANNELS   = 32;
  localparam int MIN_HOLD_TICKS = 1;
  localparam int MAX_HOLD_TICKS = 255;
  localparam int MIN_DROP_W     = 1;

  function automatic int tickCountW(input int holdTicks);
    return $clog2(holdTicks + 1);
  endfunction

endpackage

// File: rtl/pulse_stretch_channel.sv
// One pulse-stretch channel: IDLE/HOLD FSM with slow-tick hold counter.
// Optional drop counter when PULSE_STRETCH_BANK_DROP_STATS_EN is defined.
module pulse_stretch_channel
  import pulse_stretch_pkg::*;
#(
  parameter int HOLD_TICKS = 2,
  parameter int RETRIGGER  = 1,
  parameter int DROP_W     = 8
) (
  input  logic              clock,
  input  logic              resetN,
  input  logic              slowTick,
  input  logic              pulseIn,
`ifdef PULSE_STRETCH_BANK_DROP_STATS_EN
  input  logic              clearDrops,
  output logic [DROP_W-1:0] dropCount,
`endif
  output logic              pulseOut,
  output logic              holdNext
);

  localparam int CNT_W = tickCountW(HOLD_TICKS);
  localparam logic [CNT_W-1:0] LOAD = CNT_W'(HOLD_TICKS);

  if (HOLD_TICKS < MIN_HOLD_TICKS || HOLD_TICKS > MAX_HOLD_TICKS ||
      DROP_W < MIN_DROP_W || RETRIGGER < 0 || RETRIGGER > 1) begin : gBadParam
    $error("pulse_stretch_channel: parameter out of range");
  end

  chanState_t       state, stateNext;
  logic [CNT_W-1:0] count, countNext;
  logic             terminalTick;

  assign terminalTick = slowTick && (count == CNT_W'(1));

  // A tick alongside any accepted request is ignored: the reload wins.
  always_comb begin
    stateNext = state;
    countNext = count;
    case (state)
      IDLE: begin
        if (pulseIn) begin
          stateNext = HOLD;
          countNext = LOAD;
        end
      end
      HOLD: begin
        if (pulseIn) begin
          if (RETRIGGER != 0 || terminalTick) countNext = LOAD;
        end else if (slowTick) begin
          if (count == CNT_W'(1)) begin
            stateNext = IDLE;
            countNext = '0;
          end else begin
            countNext = count - CNT_W'(1);
          end
        end
      end
      default: begin
        stateNext = IDLE;
        countNext = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= stateNext;
      count <= countNext;
    end
  end

  assign pulseOut = (state == HOLD);
  assign holdNext = (stateNext == HOLD);

`ifdef PULSE_STRETCH_BANK_DROP_STATS_EN
  logic dropEvent;

  // Only a non-retriggering channel can lose a request; the terminal tick rescues it.
  assign dropEvent = (state == HOLD) && pulseIn && (RETRIGGER == 0) && !terminalTick;

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      dropCount <= '0;
    end else if (clearDrops) begin
      dropCount <= '0;
    end else if (dropEvent && (dropCount != '1)) begin
      dropCount <= dropCount + DROP_W'(1);
    end
  end
`endif

endmodule

// File: rtl/pulse_stretch_bank.sv
// Bank of independent pulse stretchers sharing one slowTick strobe.
// Define PULSE_STRETCH_BANK_DROP_STATS_EN to add clearDrops/dropCount.
module pulse_stretch_bank
  import pulse_stretch_pkg::*;
#(
  parameter int CHANNELS   = 4,
  parameter int HOLD_TICKS = 2,
  parameter int RETRIGGER  = 1,
  parameter int DROP_W     = 8
) (
  input  logic                       clock,
  input  logic                       resetN,
  input  logic                       slowTick,
  input  logic [CHANNELS-1:0]        pulseIn,
`ifdef PULSE_STRETCH_BANK_DROP_STATS_EN
  input  logic                       clearDrops,
  output logic [CHANNELS*DROP_W-1:0] dropCount,
`endif
  output logic [CHANNELS-1:0]        pulseOut,
  output logic                       busy
);

  if (CHANNELS < MIN_CHANNELS || CHANNELS > MAX_CHANNELS) begin : gBadChannels
    $error("pulse_stretch_bank: CHANNELS out of range");
  end

  logic [CHANNELS-1:0] holdNext;

  for (genvar ch = 0; ch < CHANNELS; ch++) begin : gChan
    pulse_stretch_channel #(
      .HOLD_TICKS (HOLD_TICKS),
      .RETRIGGER  (RETRIGGER),
      .DROP_W     (DROP_W)
    ) uChan (
      .clock      (clock),
      .resetN     (resetN),
      .slowTick   (slowTick),
      .pulseIn    (pulseIn[ch]),
`ifdef PULSE_STRETCH_BANK_DROP_STATS_EN
      .clearDrops (clearDrops),
      .dropCount  (dropCount[ch*DROP_W +: DROP_W]),
`endif
      .pulseOut   (pulseOut[ch]),
      .holdNext   (holdNext[ch])
    );
  end

  // Registered from the channels' next state so busy lines up with pulseOut.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) busy <= 1'b0;
    else         busy <= |holdNext;
  end

endmodule

// File: tb/tb_pulse_stretch_bank.sv
// Directed bench: one retriggering and one non-retriggering bank on shared stimulus.
module tb_pulse_stretch_bank;

  logic       clock = 1'b0;
  logic       resetN = 1'b1;
  logic       slowTick = 1'b0;
  logic [3:0] pulseIn = '0;
  logic       clearDrops = 1'b0;
  logic [3:0] pulseOutR, pulseOutN;
  logic       busyR, busyN;
`ifdef PULSE_STRETCH_BANK_DROP_STATS_EN
  logic [31:0] dropCountR;
  logic [7:0]  dropCountN;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  pulse_stretch_bank #(.CHANNELS(4), .HOLD_TICKS(2), .RETRIGGER(1), .DROP_W(8)) dutR (
    .clock      (clock),
    .resetN     (resetN),
    .slowTick   (slowTick),
    .pulseIn    (pulseIn),
`ifdef PULSE_STRETCH_BANK_DROP_STATS_EN
    .clearDrops (clearDrops),
    .dropCount  (dropCountR),
`endif
    .pulseOut   (pulseOutR),
    .busy       (busyR)
  );

  pulse_stretch_bank #(.CHANNELS(4), .HOLD_TICKS(2), .RETRIGGER(0), .DROP_W(2)) dutN (
    .clock      (clock),
    .resetN     (resetN),
    .slowTick   (slowTick),
    .pulseIn    (pulseIn),
`ifdef PULSE_STRETCH_BANK_DROP_STATS_EN
    .clearDrops (clearDrops),
    .dropCount  (dropCountN),
`endif
    .pulseOut   (pulseOutN),
    .busy       (busyN)
  );

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic checkOuts(input string tag, input logic [3:0] expR, input logic [3:0] expN);
    checkEq({tag, " outR"}, 32'(pulseOutR), 32'(expR));
    checkEq({tag, " busyR"}, 32'(busyR), 32'(|expR));
    checkEq({tag, " outN"}, 32'(pulseOutN), 32'(expN));
    checkEq({tag, " busyN"}, 32'(busyN), 32'(|expN));
  endtask

  // Leaves the bench at a falling edge with reset just released: cycle 0.
  task automatic resetBank();
    @(negedge clock);
    resetN = 1'b0;
    slowTick = 1'b0;
    pulseIn = '0;
    clearDrops = 1'b0;
    repeat (2) @(negedge clock);
    resetN = 1'b1;
  endtask

  logic [3:0] eR, eN;
  bit         tick;
  int         hi;

  initial begin
    // Reset state
    repeat (2) @(negedge clock);
    resetN = 1'b0;
    #1;
    checkOuts("reset", 4'b0000, 4'b0000);
`ifdef PULSE_STRETCH_BANK_DROP_STATS_EN
    checkEq("reset dropR", dropCountR, 32'h0);
    checkEq("reset dropN", 32'(dropCountN), 32'h0);
`endif

    // Basic stretch on ch0: pulse 10, ticks 12/16/20
    resetBank();
    hi = 0;
    for (int c = 0; c < 24; c++) begin
      eR = (c >= 11 && c <= 16) ? 4'b0001 : 4'b0000;
      checkOuts($sformatf("A c%0d", c), eR, eR);
      tick = (c == 12 || c == 16 || c == 20);
      if (tick && pulseOutR[0]) hi++;
      slowTick = tick;
      pulseIn = (c == 10) ? 4'b0001 : 4'b0000;
      @(negedge clock);
    end
    checkEq("A highSamples", 32'(hi), 32'd2);

    // ch1 pulse with same-cycle tick at 10, ticks 14/18
    resetBank();
    for (int c = 0; c < 22; c++) begin
      eR = (c >= 11 && c <= 18) ? 4'b0010 : 4'b0000;
      checkOuts($sformatf("B c%0d", c), eR, eR);
      slowTick = (c == 10 || c == 14 || c == 18);
      pulseIn = (c == 10) ? 4'b0010 : 4'b0000;
      @(negedge clock);
    end

    // Pulses 10/15, ticks every 4 from 12: retrigger vs drop
    resetBank();
    for (int c = 0; c < 28; c++) begin
      eR = (c >= 11 && c <= 20) ? 4'b0001 : 4'b0000;
      eN = (c >= 11 && c <= 16) ? 4'b0001 : 4'b0000;
      checkOuts($sformatf("C c%0d", c), eR, eN);
      slowTick = (c >= 12) && ((c - 12) % 4 == 0);
      pulseIn = (c == 10 || c == 15) ? 4'b0001 : 4'b0000;
      @(negedge clock);
    end

    // Pulses 10/13/14, ticks 12/16; later drops for saturation and clear
    resetBank();
    for (int c = 0; c < 32; c++) begin
      eR = (c >= 11) ? 4'b0001 : 4'b0000;
      eN = (c >= 11 && c <= 16) ? 4'b0001 : 4'b0000;
      if (c <= 23) checkOuts($sformatf("D c%0d", c), eR, eN);
`ifdef PULSE_STRETCH_BANK_DROP_STATS_EN
      if (c == 20) begin
        checkEq("D dropN two", 32'(dropCountN), 32'h02);
        checkEq("D dropR none", dropCountR, 32'h0);
      end
      if (c == 28) checkEq("D dropN sat", 32'(dropCountN), 32'h03);
      if (c == 29) checkEq("D dropN cleared", 32'(dropCountN), 32'h00);
      if (c == 31) checkEq("D dropN after clear", 32'(dropCountN), 32'h01);
`endif
      slowTick = (c == 12 || c == 16);
      pulseIn = (c == 10 || c == 13 || c == 14 || (c >= 24 && c <= 28) || c == 30)
                ? 4'b0001 : 4'b0000;
      clearDrops = (c == 28);
      @(negedge clock);
    end

    // Request on the terminal tick is accepted in both modes
    resetBank();
`ifdef PULSE_STRETCH_BANK_DROP_STATS_EN
    checkEq("E dropN reset", 32'(dropCountN), 32'h00);
`endif
    for (int c = 0; c < 28; c++) begin
      eR = (c >= 11 && c <= 24) ? 4'b0001 : 4'b0000;
      checkOuts($sformatf("E c%0d", c), eR, eR);
      slowTick = (c == 12 || c == 16 || c == 20 || c == 24);
      pulseIn = (c == 10 || c == 16) ? 4'b0001 : 4'b0000;
      @(negedge clock);
    end
`ifdef PULSE_STRETCH_BANK_DROP_STATS_EN
    checkEq("E dropN none", 32'(dropCountN), 32'h00);
`endif

    // Reset mid-hold on ch2; ch3 requested on release edge
    resetBank();
    for (int c = 0; c < 26; c++) begin
      eR = (c >= 11 && c <= 13) ? 4'b0100 :
           (c >= 16 && c <= 22) ? 4'b1000 : 4'b0000;
      checkOuts($sformatf("F c%0d", c), eR, eR);
      slowTick = (c == 12 || c == 18 || c == 22);
      pulseIn = (c == 10) ? 4'b0100 : (c == 15) ? 4'b1000 : 4'b0000;
      if (c == 13) begin
        resetN = 1'b0;
        #1;
        checkOuts("F async", 4'b0000, 4'b0000);
      end
      if (c == 15) resetN = 1'b1;
      @(negedge clock);
    end

    // All channels together
    resetBank();
    for (int c = 0; c < 20; c++) begin
      eR = (c >= 11 && c <= 16) ? 4'b1111 : 4'b0000;
      checkOuts($sformatf("G c%0d", c), eR, eR);
      checkEq($sformatf("G busyOr c%0d", c), 32'(busyR), 32'(|pulseOutR));
      slowTick = (c == 12 || c == 16);
      pulseIn = (c == 10) ? 4'b1111 : 4'b0000;
      @(negedge clock);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
